// File: rtl/cond_branch_unit.sv
// Flag register and branch resolver on the ALU output side.
// Resolves B, B.cond, CBZ/CBNZ with registered one-cycle br_done pulses.
module cond_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic             set_flags,
  input  logic             negative,
  input  logic             zero,
  input  logic             carry_out,
  input  logic             overflow,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  output logic             br_busy,
  output logic             br_done,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       flag_set;
  logic [3:0] eff;
  logic       cond_ok;
  logic       resolve;
  logic       take;

  function automatic logic eval_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    logic r;
    {n, z, cy, v} = f;
    r = 1'b1;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy & !z;
      4'b1001: r = !cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    flag_set = alu_valid & set_flags;
    eff      = flag_set ? {negative, zero, carry_out, overflow}
                        : flags_q;
    cond_ok  = eval_cond(cond, eff);
    flags_d  = eff;
    state_d  = state_q;
    pend_d   = pend_q;
    resolve  = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          unique case (br_type)
            2'b00: begin
              resolve = 1'b1;
              take    = 1'b1;
            end
            2'b01: begin
              resolve = 1'b1;
              take    = cond_ok;
            end
            default: begin
              if (alu_valid) begin
                resolve = 1'b1;
                take    = zero ^ br_type[0];
              end else begin
                pend_d  = br_type[0];
                state_d = WAIT;
              end
            end
          endcase
        end
      end
      WAIT: begin
        if (alu_valid) begin
          resolve = 1'b1;
          take    = zero ^ pend_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d  = resolve;
    taken_d = resolve & take;
    cnt_d   = cnt_q;
    if (taken_d && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flags_q <= 4'b0000;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign br_busy   = (state_q == WAIT);
  assign br_done   = done_q;
  assign br_taken  = taken_q;
  assign flags     = flags_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit.
// Expected branch outcomes are queued at issue and popped on br_done.
module tb_cond_branch_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             alu_valid;
  logic             set_flags;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             br_valid;
  logic [1:0]       br_type;
  logic [3:0]       cond;
  logic             br_busy;
  logic             br_done;
  logic             br_taken;
  logic [3:0]       flags;
  logic [CNT_W-1:0] taken_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_done = 0;
  int exp_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  cond_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .set_flags (set_flags),
    .negative  (negative),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow),
    .br_valid  (br_valid),
    .br_type   (br_type),
    .cond      (cond),
    .br_busy   (br_busy),
    .br_done   (br_done),
    .br_taken  (br_taken),
    .flags     (flags),
    .taken_cnt (taken_cnt)
  );

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic t);
    exp_q.push_back(t);
    n_push++;
    if (t && exp_cnt != 15) exp_cnt++;
  endtask

  task automatic clr();
    alu_valid = 0; set_flags = 0;
    negative = 0; zero = 0;
    carry_out = 0; overflow = 0;
    br_valid = 0; br_type = 2'b00; cond = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (br_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("spurious_br_done", 16'(br_done), 16'd0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("br_taken", 16'(br_taken), 16'(e));
      end
    end
  end

  // flags N=1,Z=0,C=0,V=0
  logic [15:0] tbl_n = 16'b1110_1010_1001_1010;
  // flags N=0,Z=0,C=1,V=0 ; conds 1000..1101
  logic [5:0]  tbl_c = 6'b010101;

  initial begin
    clr();
    reset_n = 0;
    repeat (2) begin
      {alu_valid, set_flags, negative, zero} = 4'($urandom);
      {carry_out, overflow, br_valid} = 3'($urandom);
      br_type = 2'($urandom);
      cond = 4'($urandom);
      tick();
    end
    clr();
    check("rst_flags", 16'(flags), 16'h0);
    check("rst_done", 16'(br_done), 16'h0);
    check("rst_taken", 16'(br_taken), 16'h0);
    check("rst_cnt", 16'(taken_cnt), 16'h0);
    check("rst_busy", 16'(br_busy), 16'h0);
    reset_n = 1;
    tick();

    // reset abandons a pending CBZ
    br_valid = 1; br_type = 2'b10;
    tick();
    clr();
    check("wait_busy", 16'(br_busy), 16'h1);
    reset_n = 0;
    tick();
    reset_n = 1;
    check("midrst_busy", 16'(br_busy), 16'h0);
    check("midrst_cnt", 16'(taken_cnt), 16'h0);
    tick();
    tick();
    check("midrst_nodone", 16'(n_done), 16'h0);

    // forwarding: register has Z=1, same-cycle SUBS clears it
    alu_valid = 1; set_flags = 1; zero = 1;
    tick();
    clr();
    check("flags_0100", 16'(flags), 16'h4);
    alu_valid = 1; set_flags = 1; negative = 1;
    br_valid = 1; br_type = 2'b01; cond = 4'b0000;
    push(0);
    tick();
    clr();
    check("flags_1000", 16'(flags), 16'h8);

    for (int i = 0; i < 16; i++) begin
      br_valid = 1; br_type = 2'b01; cond = 4'(i);
      push(tbl_n[i]);
      tick();
    end
    clr();

    alu_valid = 1; set_flags = 1; carry_out = 1;
    tick();
    clr();
    check("flags_0010", 16'(flags), 16'h2);
    for (int i = 0; i < 6; i++) begin
      br_valid = 1; br_type = 2'b01; cond = 4'(8 + i);
      push(tbl_c[i]);
      tick();
    end
    clr();

    // CBNZ waits three cycles; a branch during WAIT is dropped
    br_valid = 1; br_type = 2'b11;
    tick();
    clr();
    check("busy_c1", 16'(br_busy), 16'h1);
    br_valid = 1; br_type = 2'b00;
    tick();
    clr();
    check("busy_c2", 16'(br_busy), 16'h1);
    tick();
    check("busy_c3", 16'(br_busy), 16'h1);
    alu_valid = 1; zero = 0;
    push(1);
    tick();
    clr();
    check("busy_clr", 16'(br_busy), 16'h0);

    // immediate CBZ/CBNZ from raw zero
    br_valid = 1; br_type = 2'b10; alu_valid = 1; zero = 1;
    push(1);
    tick();
    br_type = 2'b11;
    push(0);
    tick();
    br_type = 2'b10; zero = 0;
    push(0);
    tick();
    clr();

    // WAIT resolves while flags update on the same edge
    br_valid = 1; br_type = 2'b10;
    tick();
    clr();
    alu_valid = 1; set_flags = 1; zero = 1; carry_out = 1;
    push(1);
    tick();
    clr();
    check("flags_0110", 16'(flags), 16'h6);
    check("busy_after", 16'(br_busy), 16'h0);

    // CBZ ignores register Z=1 when raw zero=0
    br_valid = 1; br_type = 2'b10; alu_valid = 1;
    push(0);
    tick();
    clr();
    tick();
    check("cnt_mid", 16'(taken_cnt), 16'(exp_cnt));

    // saturation from a clean counter
    reset_n = 0;
    tick();
    reset_n = 1;
    exp_cnt = 0;
    check("cnt_rst", 16'(taken_cnt), 16'h0);
    for (int i = 0; i < 17; i++) begin
      br_valid = 1; br_type = 2'b00;
      push(1);
      tick();
      if (i == 13) check("cnt_14", 16'(taken_cnt), 16'd14);
    end
    clr();
    check("cnt_sat", 16'(taken_cnt), 16'd15);
    tick();
    check("cnt_hold", 16'(taken_cnt), 16'd15);

    repeat (3) tick();
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    check("done_count", 16'(n_done), 16'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
